// File: rtl/rv32_fetch_unit_if.sv
// Fetch-unit bus: redirect input, imem request/response and decode handshake.
// master: fetch unit side; slave: pc/memory/decode side. Width set by PC_WIDTH.
interface rv32_fetch_unit_if #(
   parameter int PC_WIDTH = 32
);
   logic                redirect_in;
   logic [PC_WIDTH-1:0] pc_mux_in;
   logic                imem_req_out;
   logic [PC_WIDTH-1:0] imem_addr_out;
   logic                imem_gnt_in;
   logic                imem_rvalid_in;
   logic [31:0]         imem_rdata_in;
   logic                instr_valid_out;
   logic [31:0]         instr_out;
   logic [PC_WIDTH-1:0] pc_out;
   logic                decode_ready_in;

   modport master (
      input  redirect_in, pc_mux_in,
      input  imem_gnt_in, imem_rvalid_in, imem_rdata_in,
      input  decode_ready_in,
      output imem_req_out, imem_addr_out,
      output instr_valid_out, instr_out, pc_out
   );

   modport slave (
      output redirect_in, pc_mux_in,
      output imem_gnt_in, imem_rvalid_in, imem_rdata_in,
      output decode_ready_in,
      input  imem_req_out, imem_addr_out,
      input  instr_valid_out, instr_out, pc_out
   );
endinterface

// File: rtl/rv32_fetch_unit.sv
// RV32 fetch stage: issues in-order imem requests, buffers {pc,instr} for decode.
// Ports: clk_in, rst_n_in (async low), bus (rv32_fetch_unit_if.master);
// `RV32_FETCH_PERF_EN adds stall_cycles_out and fetch_count_out counters.
module rv32_fetch_unit #(
   parameter int                  PC_WIDTH        = 32,
   parameter logic [PC_WIDTH-1:0] BOOT_ADDRESS    = '0,
   parameter int                  FIFO_DEPTH      = 4,
   parameter int                  MAX_OUTSTANDING = 2
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   rv32_fetch_unit_if.master  bus
`ifdef RV32_FETCH_PERF_EN
   ,
   output logic [31:0]        stall_cycles_out,
   output logic [31:0]        fetch_count_out
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [31:0]         instr;
   } entry_t;

   logic [PC_WIDTH-1:0] fetch_pc;
   logic [OW-1:0]       outstanding;
   logic [OW-1:0]       drop_cnt;
   logic [CW-1:0]       fifo_cnt;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   entry_t              mem [FIFO_DEPTH];

   logic                req;
   logic                grant;
   logic                rv_drop;
   logic                rv_keep;
   logic                pop;
   logic                empty;
   logic [PC_WIDTH-1:0] tag_pc;

   always_comb begin
      empty   = (fifo_cnt == '0);
      // Credits: in-flight (incl. doomed) capped, and every live
      // request owns a FIFO slot so responses never overflow.
      req     = rst_n_in && !bus.redirect_in &&
                (int'(outstanding) + int'(drop_cnt) < MAX_OUTSTANDING) &&
                (int'(fifo_cnt) + int'(outstanding) < FIFO_DEPTH);
      grant   = req && bus.imem_gnt_in;
      rv_drop = bus.imem_rvalid_in && (drop_cnt != '0);
      rv_keep = bus.imem_rvalid_in && (drop_cnt == '0) &&
                (outstanding != '0);
      pop     = !empty && bus.decode_ready_in;
      // Live requests are consecutive words, so the oldest tag is
      // simply fetch_pc rewound by the outstanding count.
      tag_pc  = fetch_pc - PC_WIDTH'({outstanding, 2'b00});
   end

   assign bus.imem_req_out    = req;
   assign bus.imem_addr_out   = fetch_pc;
   assign bus.instr_valid_out = !empty;
   assign bus.instr_out       = empty ? '0 : mem[rd_ptr].instr;
   assign bus.pc_out          = empty ? '0 : mem[rd_ptr].pc;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         fetch_pc    <= BOOT_ADDRESS;
         outstanding <= '0;
         drop_cnt    <= '0;
         fifo_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else if (bus.redirect_in) begin
         fetch_pc    <= bus.pc_mux_in & ~PC_WIDTH'(3);
         drop_cnt    <= drop_cnt + outstanding -
                        OW'(rv_drop | rv_keep);
         outstanding <= '0;
         fifo_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         if (grant)
            fetch_pc <= fetch_pc + PC_WIDTH'(4);
         outstanding <= outstanding + OW'(grant) - OW'(rv_keep);
         drop_cnt    <= drop_cnt - OW'(rv_drop);
         fifo_cnt    <= fifo_cnt + CW'(rv_keep) - CW'(pop);
         if (rv_keep)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rv_keep && !bus.redirect_in)
         mem[wr_ptr] <= '{pc: tag_pc, instr: bus.imem_rdata_in};
   end

`ifdef RV32_FETCH_PERF_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stall_cycles_out <= '0;
         fetch_count_out  <= '0;
      end else begin
         if (empty)
            stall_cycles_out <= stall_cycles_out + 32'd1;
         if (pop)
            fetch_count_out <= fetch_count_out + 32'd1;
      end
   end
`endif

endmodule
